// File: rtl/spi_slave_tx_if.sv
// Handshake and SPI pin bundle for spi_slave_tx.
// The slave modport is the transmitter's view; the master modport is the SPI master and load side.
interface spi_slave_tx_if #(
  parameter int unsigned WIDTH = 12
) ();
  logic             newd;
  logic [WIDTH-1:0] din;
  logic             ready;
  logic             sclk;
  logic             cs;
  logic             miso;
  logic             busy;
  logic             done;
  logic             underrun;
  logic             abort;

  modport slave (
    input  newd, din, sclk, cs,
    output ready, miso, busy, done, underrun, abort
  );

  modport master (
    output newd, din, sclk, cs,
    input  ready, miso, busy, done, underrun, abort
  );
endinterface

// File: rtl/spi_slave_tx.sv
// SPI slave transmitter: shifts a held word out on miso, LSB first, with sclk/cs oversampled
// on the system clock. Words are loaded through a newd/ready handshake into a holding register.
module spi_slave_tx #(
  parameter int unsigned WIDTH       = 12,
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic           clk,
  input logic           rst,
  spi_slave_tx_if.slave bus
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StShift, StWaitCs} state_e;

  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q;
  logic                   sclk_prev_q, cs_prev_q;
  logic [SYNC_STAGES:0]   settle_q;
  state_e                 state_q;
  logic [WIDTH-1:0]       hold_q;
  logic [WIDTH-2:0]       shreg_q;
  logic                   full_q;
  logic [CntW-1:0]        cnt_q;
  logic                   ready_q, miso_q, busy_q, done_q, underrun_q, abort_q;

  logic settled, sclk_s, cs_s;
  logic sclk_rise, sclk_fall, cs_rise, cs_fall, last_bit;

  // Edges count only once the pipeline holds real pin samples, so a cs that is already low
  // when reset is released does not look like a fall.
  assign settled   = settle_q[SYNC_STAGES];
  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign sclk_rise = settled & sclk_s & ~sclk_prev_q;
  assign sclk_fall = settled & ~sclk_s & sclk_prev_q;
  assign cs_rise   = settled & cs_s & ~cs_prev_q;
  assign cs_fall   = settled & ~cs_s & cs_prev_q;
  assign last_bit  = (cnt_q == CntW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
      settle_q    <= '0;
      state_q     <= StIdle;
      hold_q      <= '0;
      shreg_q     <= '0;
      full_q      <= 1'b0;
      cnt_q       <= '0;
      ready_q     <= 1'b1;
      miso_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      underrun_q  <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], bus.sclk};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], bus.cs};
      sclk_prev_q <= sclk_s;
      cs_prev_q   <= cs_s;
      settle_q    <= {settle_q[SYNC_STAGES-1:0], 1'b1};
      done_q      <= 1'b0;
      underrun_q  <= 1'b0;
      abort_q     <= 1'b0;

      // ready_q is low whenever full_q is set, so a load never collides with the move below.
      if (bus.newd && ready_q) begin
        hold_q  <= bus.din;
        full_q  <= 1'b1;
        ready_q <= 1'b0;
      end

      unique case (state_q)
        StIdle: begin
          if (cs_fall) begin
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            state_q <= StShift;
            if (full_q) begin
              shreg_q <= hold_q[WIDTH-1:1];
              miso_q  <= hold_q[0];
              full_q  <= 1'b0;
              ready_q <= 1'b1;
            end else begin
              shreg_q    <= '0;
              miso_q     <= 1'b0;
              underrun_q <= 1'b1;
            end
          end
        end
        StShift: begin
          if (sclk_rise && last_bit) begin
            // A cs rise seen together with the final rise still completes the frame.
            cnt_q  <= cnt_q + CntW'(1);
            done_q <= 1'b1;
            miso_q <= 1'b0;
            if (cs_rise) begin
              busy_q  <= 1'b0;
              state_q <= StIdle;
            end else begin
              state_q <= StWaitCs;
            end
          end else if (cs_rise) begin
            abort_q <= 1'b1;
            busy_q  <= 1'b0;
            miso_q  <= 1'b0;
            state_q <= StIdle;
          end else if (sclk_rise) begin
            cnt_q <= cnt_q + CntW'(1);
          end else if (sclk_fall) begin
            miso_q  <= shreg_q[0];
            shreg_q <= shreg_q >> 1;
          end
        end
        StWaitCs: begin
          miso_q <= 1'b0;
          if (cs_rise) begin
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.ready    = ready_q;
  assign bus.miso     = miso_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.underrun = underrun_q;
  assign bus.abort    = abort_q;

endmodule
